// File: rtl/stream_range.sv
// stream_range: arithmetic-sequence stream source behind a call/completion handshake.
// Optional build macro STREAM_RANGE_LAST_EN adds the sOut_last end-of-stream marker.
module stream_range #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    input  logic [N-1:0] start,
    input  logic [N-1:0] step,
    input  logic [N-1:0] count,
    output logic [N-1:0] sOut,
    output logic         sOut_valid,
    input  logic         sOut_ready
`ifdef STREAM_RANGE_LAST_EN
    ,
    output logic         sOut_last
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [N-1:0] cur;
    logic [N-1:0] step_r;
    logic [N-1:0] rem;
    logic         accept;
    logic         xfer;

    assign accept = (state == IDLE) && in_valid;
    assign xfer   = (state == RUN) && sOut_ready;

    // NOTE: every variable is given a default before the case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (in_valid)        state_next = (count != '0) ? RUN : DONE;
            RUN:  if (xfer && rem == N'(1)) state_next = DONE;
            DONE: if (out_ready)       state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur    <= '0;
            step_r <= '0;
            rem    <= '0;
        end else if (accept) begin
            cur    <= start;
            step_r <= step;
            rem    <= count;
        end else if (xfer) begin
            cur <= cur + step_r;
            rem <= rem - N'(1);
        end
    end

    // Outputs decode registered state only; arguments are never seen combinationally.
    assign in_ready   = (state == IDLE);
    assign sOut_valid = (state == RUN);
    assign out_valid  = (state == DONE);
    assign sOut       = cur;

`ifdef STREAM_RANGE_LAST_EN
    assign sOut_last  = (state == RUN) && (rem == N'(1));
`endif

endmodule

// File: tb/tb_stream_range.sv
// Self-checking bench for stream_range (N=8), scoreboard of expected stream elements.
// Build with STREAM_RANGE_LAST_EN defined to also check sOut_last.
module tb_stream_range;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] start;
    logic [7:0] step;
    logic [7:0] count;
    logic [7:0] sOut;
    logic       sOut_valid;
    logic       sOut_ready;
`ifdef STREAM_RANGE_LAST_EN
    logic       sOut_last;
`endif

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    stream_range #(.N(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .start      (start),
        .step       (step),
        .count      (count),
        .sOut       (sOut),
        .sOut_valid (sOut_valid),
        .sOut_ready (sOut_ready)
`ifdef STREAM_RANGE_LAST_EN
        ,
        .sOut_last  (sOut_last)
`endif
    );

    // Expected elements are queued at call time; caller is at posedge+1 phase on entry and exit.
    task automatic issue_call(input logic [7:0] s, input logic [7:0] st, input logic [7:0] c);
        logic [7:0] v;
        int w;
        v = s;
        for (int i = 0; i < int'(c); i++) begin
            exp_q.push_back(v);
            v = v + st;
        end
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            n_assert++; n_fail++;
            $display("FAIL call_wait: in_ready got %b required 1", in_ready);
        end
        start = s; step = st; count = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        start = 8'hA5; step = 8'h5A; count = 8'h77;
    endtask

    task automatic finish_call();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_assert++;
        if ({in_ready, out_valid, sOut_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL reset_flags: {in_ready,out_valid,sOut_valid} got %b required 100",
                     {in_ready, out_valid, sOut_valid});
        end
        n_assert++;
        if (sOut !== 8'd0) begin
            n_fail++; $display("FAIL reset_sOut: got %0d required 0", sOut);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic [7:0] e;
        sOut_ready = 1'b1;
        issue_call(8'd3, 8'd1, 8'd4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q[0] : 8'hXX;
            n_assert++;
            if ({sOut_valid, in_ready, out_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL basic_flags[%0d]: {sOut_valid,in_ready,out_valid} got %b required 100",
                         i, {sOut_valid, in_ready, out_valid});
            end
`ifdef STREAM_RANGE_LAST_EN
            n_assert++;
            if (sOut_last !== (i == 3)) begin
                n_fail++; $display("FAIL basic_last[%0d]: got %b required %b", i, sOut_last, (i == 3));
            end
`endif
            n_assert++;
            if (sOut !== e) begin
                n_fail++; $display("FAIL basic_elem[%0d]: got %0d required %0d", i, sOut, e);
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_assert++;
        if ({out_valid, sOut_valid, in_ready} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_done: {out_valid,sOut_valid,in_ready} got %b required 100",
                     {out_valid, sOut_valid, in_ready});
        end
        @(posedge clk); #1;
        finish_call();
        @(negedge clk);
        n_assert++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_idle: {in_ready,out_valid} got %b required 10", {in_ready, out_valid});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int xfers = 0;
        int done_cyc = -1;
        bit stalled = 1'b0;
        logic [7:0] held = '0;
        logic [7:0] e;
        issue_call(8'd10, 8'd5, 8'd3);
        for (int c = 0; c < 12; c++) begin
            sOut_ready = (c < 6) ? pat[c][0] : 1'b1;
            @(negedge clk);
            if (out_valid) begin
                done_cyc = c;
                break;
            end
            if (sOut_valid) begin
                if (stalled) begin
                    n_assert++;
                    if (sOut !== held) begin
                        n_fail++; $display("FAIL bp_stable[%0d]: got %0d required %0d", c, sOut, held);
                    end
                end
                if (sOut_ready) begin
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
                    n_assert++;
                    if (sOut !== e) begin
                        n_fail++; $display("FAIL bp_elem[%0d]: got %0d required %0d", c, sOut, e);
                    end
                    xfers++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    held = sOut;
                end
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (xfers !== 3) begin
            n_fail++; $display("FAIL bp_xfers: got %0d required 3", xfers);
        end
        n_assert++;
        if (done_cyc !== 6) begin
            n_fail++; $display("FAIL bp_done_cycle: got %0d required 6", done_cyc);
        end
        @(posedge clk); #1;
        finish_call();
        sOut_ready = 1'b1;
    endtask

    task automatic test_wrap();
        logic [7:0] args[2][3] = '{'{8'd250, 8'd4, 8'd3}, '{8'd1, 8'hFF, 8'd3}};
        logic [7:0] want[2][3] = '{'{8'd250, 8'd254, 8'd2}, '{8'd1, 8'd0, 8'd255}};
        sOut_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue_call(args[k][0], args[k][1], args[k][2]);
            exp_q.delete();
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                n_assert++;
                if (sOut_valid !== 1'b1 || sOut !== want[k][i]) begin
                    n_fail++;
                    $display("FAIL wrap_elem[%0d][%0d]: valid %b data %0d required valid 1 data %0d",
                             k, i, sOut_valid, sOut, want[k][i]);
                end
`ifdef STREAM_RANGE_LAST_EN
                n_assert++;
                if (sOut_last !== (i == 2)) begin
                    n_fail++; $display("FAIL wrap_last[%0d][%0d]: got %b required %b", k, i, sOut_last, (i == 2));
                end
`endif
                @(posedge clk); #1;
            end
            n_assert++;
            if (out_valid !== 1'b1) begin
                n_fail++; $display("FAIL wrap_done[%0d]: out_valid got %b required 1", k, out_valid);
            end
            finish_call();
        end
    endtask

    task automatic test_zero_count();
        sOut_ready = 1'b1;
        issue_call(8'd9, 8'd1, 8'd0);
        @(negedge clk);
        n_assert++;
        if ({out_valid, sOut_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL zero_done: {out_valid,sOut_valid} got %b required 10", {out_valid, sOut_valid});
        end
        @(posedge clk); #1;
        finish_call();
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        sOut_ready = 1'b1;
        issue_call(8'd7, 8'd2, 8'd1);
        @(negedge clk);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
        n_assert++;
        if (sOut !== e) begin
            n_fail++; $display("FAIL b2b_first: got %0d required %0d", sOut, e);
        end
        @(posedge clk); #1;
        exp_q.push_back(8'd40);
        exp_q.push_back(8'd41);
        start = 8'd40; step = 8'd1; count = 8'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_assert++;
            if ({out_valid, in_ready, sOut_valid} !== 3'b100) begin
                n_fail++;
                $display("FAIL b2b_hold[%0d]: {out_valid,in_ready,sOut_valid} got %b required 100",
                         i, {out_valid, in_ready, sOut_valid});
            end
            @(posedge clk); #1;
        end
        finish_call();
        @(negedge clk);
        n_assert++;
        if ({in_ready, out_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_release: {in_ready,out_valid} got %b required 10", {in_ready, out_valid});
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            n_assert++;
            if (sOut_valid !== 1'b1 || sOut !== e) begin
                n_fail++;
                $display("FAIL b2b_second[%0d]: valid %b data %0d required valid 1 data %0d", i, sOut_valid, sOut, e);
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_second_done: out_valid got %b required 1", out_valid);
        end
        finish_call();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e;
        sOut_ready = 1'b1;
        issue_call(8'h20, 8'd1, 8'd6);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            n_assert++;
            if (sOut !== e) begin
                n_fail++; $display("FAIL rst_pre[%0d]: got %0d required %0d", i, sOut, e);
            end
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        exp_q.delete();
        n_assert++;
        if ({in_ready, out_valid, sOut_valid, sOut} !== {3'b100, 8'd0}) begin
            n_fail++;
            $display("FAIL rst_mid: {in_ready,out_valid,sOut_valid} %b sOut %0d required 100 and 0",
                     {in_ready, out_valid, sOut_valid}, sOut);
        end
`ifdef STREAM_RANGE_LAST_EN
        n_assert++;
        if (sOut_last !== 1'b0) begin
            n_fail++; $display("FAIL rst_last: got %b required 0", sOut_last);
        end
`endif
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_assert++;
            if ({out_valid, sOut_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL rst_quiet[%0d]: {out_valid,sOut_valid} got %b required 00", i, {out_valid, sOut_valid});
            end
        end
        @(posedge clk); #1;
        issue_call(8'd0, 8'd3, 8'd2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            n_assert++;
            if (sOut_valid !== 1'b1 || sOut !== e) begin
                n_fail++;
                $display("FAIL rst_restart[%0d]: valid %b data %0d required valid 1 data %0d", i, sOut_valid, sOut, e);
            end
            @(posedge clk); #1;
        end
        n_assert++;
        if (out_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_restart_done: out_valid got %b required 1", out_valid);
        end
        finish_call();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sOut_ready = 1'b0;
        start = '0; step = '0; count = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
